// File: rtl/alarm_time_keeper.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alarm_time_keeper
//
// Holds the programmed alarm time, edited by one-cycle increment pulses from
// the alarm-setting FSM, compares it with the running clock time and drives
// the buzzer enable through a small ring/timeout FSM.
//
// Optional feature: define ALARM_SNOOZE_EN to add a snooze input, a snoozing
// status output and a SNOOZE state that silences the ring for SNOOZE_LEN
// cycles before ringing again. Without it the FSM has only IDLE and RING.
//
// Parameters
//   HOUR_MAX   highest alarm hour, wraps to 0 afterwards
//   MIN_MAX    highest alarm minute, wraps to 0 afterwards
//   RING_LEN   cycles the ring stays high without a stop request
//   SNOOZE_LEN cycles of silence per snooze (ALARM_SNOOZE_EN only)
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   hours_inc   pulse: increment alarm hour
//   mins_inc    pulse: increment alarm minute
//   alarm_on    level: alarm armed
//   stop        pulse: silence the alarm
//   snooze      pulse: snooze a ringing alarm (ALARM_SNOOZE_EN only)
//   cur_hour    current clock hour 0..23
//   cur_min     current clock minute 0..59
//   alarm_hour  programmed alarm hour (registered)
//   alarm_min   programmed alarm minute (registered)
//   ring        buzzer enable (registered)
//   snoozing    snooze period active (registered, ALARM_SNOOZE_EN only)
// ---------------------------------------------------------------------------
module alarm_time_keeper #(
  parameter int HOUR_MAX   = 23,
  parameter int MIN_MAX    = 59,
  parameter int RING_LEN   = 60,
  parameter int SNOOZE_LEN = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hours_inc,
  input  logic       mins_inc,
  input  logic       alarm_on,
  input  logic       stop,
`ifdef ALARM_SNOOZE_EN
  input  logic       snooze,
  output logic       snoozing,
`endif
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       ring
);

  // Counter must hold the larger of the two reload values.
  localparam int CNT_MAX = (RING_LEN > SNOOZE_LEN) ? RING_LEN : SNOOZE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RING_RELOAD   = CNT_W'(RING_LEN - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_RELOAD = CNT_W'(SNOOZE_LEN - 1);
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] ST_SNOOZE = 2'd2;
`endif

  logic [4:0]       r_alarm_hour;
  logic [5:0]       r_alarm_min;
  logic             r_match_q;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ring;
`ifdef ALARM_SNOOZE_EN
  logic             r_snoozing;
`endif

  logic w_match;
  logic w_trigger;

  assign w_match   = (cur_hour == r_alarm_hour) && (cur_min == r_alarm_min);
  // Only the rising edge of match fires, so a held match rings once and
  // arming the alarm while already matching stays silent.
  assign w_trigger = w_match && !r_match_q && alarm_on;

  // -------------------------------------------------------------------------
  // Alarm time edit and match history. Edits run in every FSM state and the
  // minute wrap never carries into the hour.
  // -------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking assignment so that all
  // flops sample pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm_hour <= '0;
      r_alarm_min  <= '0;
      // Starts high so the 00:00 == 00:00 match right after reset is not
      // mistaken for a fresh match edge.
      r_match_q    <= 1'b1;
    end else begin
      if (hours_inc)
        r_alarm_hour <= (r_alarm_hour == 5'(HOUR_MAX)) ? 5'd0 : r_alarm_hour + 5'd1;
      if (mins_inc)
        r_alarm_min  <= (r_alarm_min == 6'(MIN_MAX)) ? 6'd0 : r_alarm_min + 6'd1;
      r_match_q <= w_match;
    end
  end

  // -------------------------------------------------------------------------
  // Ring / timeout FSM. Entering RING loads RING_LEN-1 and the ring leaves
  // when the counter reaches 0, giving exactly RING_LEN high cycles.
  // stop and alarm_on=0 take priority over every other transition.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ring     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snoozing <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ring <= 1'b0;
          if (w_trigger) begin
            r_state <= ST_RING;
            r_cnt   <= RING_RELOAD;
            r_ring  <= 1'b1;
          end
        end

        ST_RING: begin
          // A trigger here is ignored; the counter is never reloaded.
          if (stop || !alarm_on) begin
            r_state <= ST_IDLE;
            r_ring  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            r_state    <= ST_SNOOZE;
            r_cnt      <= SNOOZE_RELOAD;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b1;
`endif
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_ring  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop || !alarm_on) begin
            r_state    <= ST_IDLE;
            r_snoozing <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state    <= ST_RING;
            r_cnt      <= RING_RELOAD;
            r_ring     <= 1'b1;
            r_snoozing <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_ring  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          r_snoozing <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign alarm_hour = r_alarm_hour;
  assign alarm_min  = r_alarm_min;
  assign ring       = r_ring;
`ifdef ALARM_SNOOZE_EN
  assign snoozing   = r_snoozing;
`endif

endmodule
